// File: rtl/dct_pkg.sv
// Shared constants, types and sizing helpers for the 2-D DCT coefficient datapath.
package dct_pkg;

  localparam int N     = 8;
  localparam int IDX_W = 3;
  localparam int COS_W = 32;

  // Accumulator width: signed pixel (PIX_W+1) times cos_term, plus 6 bits of headroom for 64 terms.
  function automatic int acc_w(input int pix_w);
    return pix_w + 1 + COS_W + 6;
  endfunction

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } dct_state_e;

endpackage

// File: rtl/dct_round_sat.sv
// Combinational round-half-up by COS_FRAC fractional bits, then clamp to a signed OUT_W result.
module dct_round_sat #(
  parameter int ACC_W    = 47,
  parameter int COS_FRAC = 0,
  parameter int OUT_W    = 32
) (
  input  logic signed [ACC_W-1:0] acc_i,
  output logic signed [OUT_W-1:0] coeff_o
);

  // One guard bit so adding the rounding constant can never wrap.
  localparam int EW = ACC_W + 1;
  localparam logic signed [EW-1:0] MAX_V = EW'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [EW-1:0] MIN_V = EW'(-(64'sd1 <<< (OUT_W - 1)));

  logic signed [EW-1:0] ext;
  logic signed [EW-1:0] shifted;

  assign ext = EW'(acc_i);

  generate
    if (COS_FRAC > 0) begin : g_round
      localparam logic signed [EW-1:0] HALF = EW'(64'sd1 <<< (COS_FRAC - 1));
      assign shifted = (ext + HALF) >>> COS_FRAC;
    end else begin : g_noround
      assign shifted = ext;
    end
  endgenerate

  // Clamp the rounded value into the representable output range.
  always_comb begin
    coeff_o = OUT_W'(shifted);
    if (shifted > MAX_V) begin
      coeff_o = OUT_W'(MAX_V);
    end else if (shifted < MIN_V) begin
      coeff_o = OUT_W'(MIN_V);
    end
  end

endmodule

// File: rtl/dct_coeff_accum.sv
// Multiply-accumulate of one 8x8 block against a per-(k1,k2) cosine LUT, producing one DCT coefficient.
module dct_coeff_accum
  import dct_pkg::*;
#(
  parameter int PIX_W       = 8,
  parameter int COS_FRAC    = 0,
  parameter int OUT_W       = 32,
  parameter int LEVEL_SHIFT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic [PIX_W-1:0]        pix_in,
  input  logic                    pix_valid,
  output logic                    pix_ready,
  output logic [IDX_W-1:0]        n1,
  output logic [IDX_W-1:0]        n2,
  input  logic signed [COS_W-1:0] cos_term,
  output logic signed [OUT_W-1:0] coeff_out,
  output logic                    coeff_valid,
  input  logic                    coeff_ready,
  output logic                    busy
);

  localparam int ACC_W  = acc_w(PIX_W);
  localparam int PROD_W = PIX_W + 1 + COS_W;
  localparam logic signed [PIX_W:0] HALF_RANGE = (PIX_W + 1)'(1) << (PIX_W - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  dct_state_e state_q, state_d;
  logic [IDX_W-1:0] n1_q, n1_d;
  logic [IDX_W-1:0] n2_q, n2_d;

  logic signed [PROD_W-1:0] prod_q;
  logic signed [PROD_W-1:0] prod_d;
  logic                     prod_v_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  acc_d;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [OUT_W-1:0]  coeff_q;
  logic signed [OUT_W-1:0]  coeff_rs;
  logic                     coeff_v_q;

  logic                     xfer;
  logic                     last_pix;
  logic signed [PIX_W:0]    pix_s;

  // clear wins over any handshake, so a pixel offered alongside it is never taken.
  assign pix_ready = (state_q == ACCUM) && !clear;
  assign xfer      = pix_valid && pix_ready;
  assign last_pix  = (n1_q == IDX_LAST) && (n2_q == IDX_LAST);

  assign pix_s  = (LEVEL_SHIFT != 0) ? ($signed({1'b0, pix_in}) - HALF_RANGE)
                                     : $signed({1'b0, pix_in});
  assign prod_d = PROD_W'(pix_s) * PROD_W'(cos_term);

  // The previous product is folded in one cycle after it was formed.
  assign acc_sum = prod_v_q ? (acc_q + ACC_W'(prod_q)) : acc_q;

  dct_round_sat #(
    .ACC_W   (ACC_W),
    .COS_FRAC(COS_FRAC),
    .OUT_W   (OUT_W)
  ) u_round_sat (
    .acc_i  (acc_sum),
    .coeff_o(coeff_rs)
  );

  // Next state and raster index; the index only moves on an accepted pixel.
  always_comb begin
    state_d = state_q;
    n1_d    = n1_q;
    n2_d    = n2_q;
    acc_d   = acc_sum;
    if (xfer) begin
      n2_d = n2_q + IDX_W'(1);
      if (n2_q == IDX_LAST) begin
        n1_d = n1_q + IDX_W'(1);
      end
    end
    case (state_q)
      ACCUM: begin
        if (xfer && last_pix) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = DONE;
      end
      DONE: begin
        if (coeff_ready) begin
          state_d = ACCUM;
          acc_d   = '0;
        end
      end
      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  // Control registers: FSM state, LUT index, coefficient valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ACCUM;
      n1_q      <= '0;
      n2_q      <= '0;
      prod_v_q  <= 1'b0;
      coeff_v_q <= 1'b0;
    end else if (clear) begin
      state_q   <= ACCUM;
      n1_q      <= '0;
      n2_q      <= '0;
      prod_v_q  <= 1'b0;
      coeff_v_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      n1_q     <= n1_d;
      n2_q     <= n2_d;
      prod_v_q <= xfer;
      if (state_q == DRAIN) begin
        coeff_v_q <= 1'b1;
      end else if (state_q == DONE && coeff_ready) begin
        coeff_v_q <= 1'b0;
      end
    end
  end

  // Datapath registers: product, running sum and the held coefficient.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q  <= '0;
      acc_q   <= '0;
      coeff_q <= '0;
    end else if (clear) begin
      acc_q <= '0;
    end else begin
      if (xfer) begin
        prod_q <= prod_d;
      end
      acc_q <= acc_d;
      if (state_q == DRAIN) begin
        coeff_q <= coeff_rs;
      end
    end
  end

  assign n1          = n1_q;
  assign n2          = n2_q;
  assign coeff_out   = coeff_q;
  assign coeff_valid = coeff_v_q;
  assign busy        = (n1_q != '0) || (n2_q != '0) || (state_q != ACCUM);

endmodule

// File: tb/tb_dct_coeff_accum.sv
// Bench for dct_coeff_accum: four parameter variants share one stimulus and are checked against a sum-of-products model.
module tb_dct_coeff_accum;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clear = 1'b0;
  logic       pix_valid = 1'b0;
  logic       coeff_ready = 1'b0;
  logic [7:0] pix_in = 8'd0;

  always #5 clk = ~clk;

  logic signed [31:0] cos_lut [64];
  logic               pr [4];
  logic               cv [4];
  logic               bs [4];
  logic [2:0]         n1s [4];
  logic [2:0]         n2s [4];
  logic signed [31:0] cs [4];
  logic signed [31:0] co0, co2, co3;
  logic signed [11:0] co1;

  assign cs[0] = cos_lut[{n1s[0], n2s[0]}];
  assign cs[1] = cos_lut[{n1s[1], n2s[1]}];
  assign cs[2] = cos_lut[{n1s[2], n2s[2]}];
  assign cs[3] = cos_lut[{n1s[3], n2s[3]}];

  dct_coeff_accum #(.PIX_W(8), .COS_FRAC(0), .OUT_W(32), .LEVEL_SHIFT(1)) u0 (
    .clk(clk), .rst(rst), .clear(clear), .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_ready(pr[0]), .n1(n1s[0]), .n2(n2s[0]), .cos_term(cs[0]), .coeff_out(co0),
    .coeff_valid(cv[0]), .coeff_ready(coeff_ready), .busy(bs[0]));
  dct_coeff_accum #(.PIX_W(8), .COS_FRAC(0), .OUT_W(12), .LEVEL_SHIFT(1)) u1 (
    .clk(clk), .rst(rst), .clear(clear), .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_ready(pr[1]), .n1(n1s[1]), .n2(n2s[1]), .cos_term(cs[1]), .coeff_out(co1),
    .coeff_valid(cv[1]), .coeff_ready(coeff_ready), .busy(bs[1]));
  dct_coeff_accum #(.PIX_W(8), .COS_FRAC(1), .OUT_W(32), .LEVEL_SHIFT(1)) u2 (
    .clk(clk), .rst(rst), .clear(clear), .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_ready(pr[2]), .n1(n1s[2]), .n2(n2s[2]), .cos_term(cs[2]), .coeff_out(co2),
    .coeff_valid(cv[2]), .coeff_ready(coeff_ready), .busy(bs[2]));
  dct_coeff_accum #(.PIX_W(8), .COS_FRAC(0), .OUT_W(32), .LEVEL_SHIFT(0)) u3 (
    .clk(clk), .rst(rst), .clear(clear), .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_ready(pr[3]), .n1(n1s[3]), .n2(n2s[3]), .cos_term(cs[3]), .coeff_out(co3),
    .coeff_valid(cv[3]), .coeff_ready(coeff_ready), .busy(bs[3]));

  int n_chk = 0;
  int n_pass = 0;
  int n_fail_print = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) begin
      n_pass++;
    end else begin
      if (n_fail_print < 40) begin
        $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
      n_fail_print++;
    end
  endtask

  function automatic longint sat(input longint v, input int w);
    longint mx, mn;
    mx = (64'sd1 <<< (w - 1)) - 1;
    mn = -mx - 1;
    if (v > mx) return mx;
    if (v < mn) return mn;
    return v;
  endfunction

  // Reference model: block position, running sums of pixel*cos, and the coefficient each variant must show.
  int     m_idx = 0;
  int     m_phase = 0;
  longint s_ls = 0;
  longint s_nl = 0;
  bit     m_valid = 1'b0;
  longint m_co [4] = '{0, 0, 0, 0};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_idx <= 0; m_phase <= 0; s_ls <= 0; s_nl <= 0; m_valid <= 1'b0;
      for (int i = 0; i < 4; i++) m_co[i] <= 0;
    end else if (clear) begin
      m_idx <= 0; m_phase <= 0; s_ls <= 0; s_nl <= 0; m_valid <= 1'b0;
    end else begin
      case (m_phase)
        0: if (pix_valid) begin
          s_ls <= s_ls + (longint'(pix_in) - 128) * longint'(cos_lut[m_idx]);
          s_nl <= s_nl + longint'(pix_in) * longint'(cos_lut[m_idx]);
          if (m_idx == 63) begin
            m_idx <= 0;
            m_phase <= 1;
          end else begin
            m_idx <= m_idx + 1;
          end
        end
        1: begin
          m_phase <= 2;
          m_valid <= 1'b1;
          m_co[0] <= sat(s_ls, 32);
          m_co[1] <= sat(s_ls, 12);
          m_co[2] <= sat((s_ls + 1) >>> 1, 32);
          m_co[3] <= sat(s_nl, 32);
        end
        default: if (coeff_ready) begin
          m_valid <= 1'b0; m_phase <= 0; s_ls <= 0; s_nl <= 0;
        end
      endcase
    end
  end

  // Every cycle, all four variants against the model, sampled mid-cycle.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("pix_ready[%0d]", i), pr[i], (m_phase == 0) && !clear);
      chk($sformatf("n1[%0d]", i), n1s[i], m_idx / 8);
      chk($sformatf("n2[%0d]", i), n2s[i], m_idx % 8);
      chk($sformatf("busy[%0d]", i), bs[i], (m_idx != 0) || (m_phase != 0));
      chk($sformatf("coeff_valid[%0d]", i), cv[i], m_valid);
    end
    chk("coeff_out0", co0, m_co[0]);
    chk("coeff_out1_w12", co1, m_co[1]);
    chk("coeff_out2_frac1", co2, m_co[2]);
    chk("coeff_out3_nols", co3, m_co[3]);
  end

  int blk [64];

  task automatic fill(input int v);
    for (int i = 0; i < 64; i++) blk[i] = v;
  endtask

  task automatic set_cos_const(input int v);
    for (int i = 0; i < 64; i++) cos_lut[i] = 32'(v);
  endtask

  // Offer blk[0..cnt-1]; with gap>0 every gap-th cycle pix_valid is dropped (junk data).
  task automatic send(input int cnt, input int gap);
    int i, cyc, tick;
    bit ok;
    i = 0; cyc = 0; tick = 0;
    while (i < cnt && cyc < 2000) begin
      tick++;
      if (gap != 0 && (tick % gap) == 0) begin
        pix_valid = 1'b0;
        pix_in = 8'($urandom);
      end else begin
        pix_valid = 1'b1;
        pix_in = 8'(blk[i]);
      end
      #0;
      ok = pix_valid && pr[0];
      @(posedge clk); #1;
      cyc++;
      if (ok) i++;
    end
    pix_valid = 1'b0;
    if (i < cnt) chk("send_timeout", i, cnt);
  endtask

  // Called right after the last transfer edge: latency, backpressure with junk pixels, then accept.
  task automatic finish(input int hold);
    pix_valid = 1'b1;
    pix_in = 8'($urandom);
    chk("lat_drain_valid", cv[0], 0);
    @(posedge clk); #1;
    chk("lat_valid", cv[0], 1);
    for (int k = 0; k < hold; k++) begin
      pix_in = 8'($urandom);
      @(posedge clk); #1;
      chk("hold_valid", cv[0], 1);
      chk("hold_ready", pr[0], 0);
    end
    coeff_ready = 1'b1;
    @(posedge clk); #1;
    coeff_ready = 1'b0;
    pix_valid = 1'b0;
    chk("accept_valid", cv[0], 0);
    chk("accept_ready", pr[0], 1);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    pix_valid = 1'b1;
    pix_in = 8'($urandom);
    #1;
    chk("clear_ready", pr[0], 0);
    @(posedge clk); #1;
    clear = 1'b0;
    pix_valid = 1'b0;
    chk("clear_n1", n1s[0], 0);
    chk("clear_n2", n2s[0], 0);
    chk("clear_busy", bs[0], 0);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    #1;
    chk("rst_ready", pr[0], 1);
    chk("rst_n1", n1s[0], 0);
    chk("rst_n2", n2s[0], 0);
    chk("rst_valid", cv[0], 0);
    chk("rst_coeff", co0, 0);
    chk("rst_busy", bs[0], 0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    set_cos_const(1);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("init_ready", pr[0], 1);
    chk("init_n1", n1s[0], 0);
    chk("init_valid", cv[0], 0);
    chk("init_coeff", co0, 0);
    chk("init_busy", bs[0], 0);

    // DC blocks: full-scale and zero pixels.
    fill(255); send(64, 0); finish(0);
    chk("dc255", co0, 8128);
    chk("dc255_w12", co1, 2047);
    chk("dc255_nols", co3, 16320);
    fill(0); send(64, 0); finish(0);
    chk("dc0", co0, -8192);
    chk("dc0_w12", co1, -2048);
    chk("dc0_frac1", co2, -4096);

    // Ramp with bubbles, then backpressure, then an immediate all-128 block.
    for (int i = 0; i < 64; i++) blk[i] = 4 * i;
    send(64, 3); finish(5);
    chk("ramp", co0, -128);
    fill(128); send(64, 0); finish(0);
    chk("mid128", co0, 0);

    // Sum 8127 with one fractional bit rounds half up.
    fill(255); blk[63] = 254;
    send(64, 0); finish(1);
    chk("frac_round", co2, 4064);
    chk("frac_raw", co0, 8127);

    // Abort after 30 transfers, then a clean block of 200s.
    for (int i = 0; i < 64; i++) blk[i] = int'($urandom_range(0, 255));
    send(30, 0); pulse_clear();
    fill(200); send(64, 0); finish(2);
    chk("after_clear", co0, 4608);

    // Reset mid-block and while holding a result.
    fill(255); send(20, 0); pulse_rst();
    send(64, 0);
    @(posedge clk); #1;
    chk("done_before_rst", cv[0], 1);
    pulse_rst();
    send(64, 0); finish(0);
    chk("after_rst", co0, 8128);

    // Randomised blocks: random LUTs, pixels, bubbles, hold times, occasional aborts.
    for (int b = 0; b < 10; b++) begin
      for (int i = 0; i < 64; i++) begin
        if (b % 3 == 2) cos_lut[i] = 32'($urandom);
        else cos_lut[i] = 32'($urandom_range(0, 2000)) - 32'd1000;
        blk[i] = int'($urandom_range(0, 255));
      end
      if (b % 4 == 1) begin
        send(int'($urandom_range(1, 63)), int'($urandom_range(0, 4)));
        pulse_clear();
      end
      send(64, (b % 2 == 0) ? 0 : int'($urandom_range(2, 5)));
      finish(int'($urandom_range(0, 4)));
    end

    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
